// File: rtl/conv_encoder_table_pkg.sv
// Shared trellis definitions for the table-driven convolutional encoder and the Viterbi decoder.
// Code geometry, table widths and frame-control state encodings live here.
package conv_encoder_table_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int CODE_N     = 2;
    localparam int CODE_K     = 1;
    localparam int CODE_M     = 4;
    localparam int STATE_W    = CODE_M - CODE_K;
    localparam int FRAME_L    = 7;
    localparam int TAIL_T     = (CODE_M - 1) / CODE_K;
    localparam int DATA_SYMS  = FRAME_L - TAIL_T;
    localparam int CNT_W      = clog2(FRAME_L + 1);
    localparam int NUM_STATES = 1 << STATE_W;
    localparam int NUM_INPUTS = 1 << CODE_K;
    localparam int TBL_DEPTH  = NUM_STATES * NUM_INPUTS;
    localparam int TBL_IDX_W  = STATE_W + CODE_K;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TAIL = 2'd1,
        DONE = 2'd2
    } enc_fsm_e;

endpackage

// File: rtl/conv_encoder_table_trellis_table.sv
// Next-state / output trellis RAM: one write port (the load interface) and
// one combinational read port indexed by (state, input).
module trellis_table
    import conv_encoder_table_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [STATE_W-1:0] wr_state,
    input  logic [CODE_K-1:0]  wr_input,
    input  logic [STATE_W-1:0] wr_next,
    input  logic [CODE_N-1:0]  wr_out,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [CODE_K-1:0]  rd_input,
    output logic [STATE_W-1:0] rd_next,
    output logic [CODE_N-1:0]  rd_out
);

    logic [STATE_W-1:0] nxt_q [TBL_DEPTH];
    logic [STATE_W-1:0] nxt_d [TBL_DEPTH];
    logic [CODE_N-1:0]  out_q [TBL_DEPTH];
    logic [CODE_N-1:0]  out_d [TBL_DEPTH];
    logic [TBL_IDX_W-1:0] wr_idx;
    logic [TBL_IDX_W-1:0] rd_idx;

    assign wr_idx = {wr_state, wr_input};
    assign rd_idx = {rd_state, rd_input};

    always_comb begin
        nxt_d = nxt_q;
        out_d = out_q;
        if (we) begin
            nxt_d[wr_idx] = wr_next;
            out_d[wr_idx] = wr_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                nxt_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            nxt_q <= nxt_d;
            out_q <= out_d;
        end
    end

    assign rd_next = nxt_q[rd_idx];
    assign rd_out  = out_q[rd_idx];

endmodule

// File: rtl/conv_encoder_table.sv
// Table-driven convolutional encoder: one frame of data symbols plus zero tail
// symbols, each mapped through the loaded trellis onto a valid/ready output register.
module conv_encoder_table
    import conv_encoder_table_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic               load,
    input  logic [STATE_W-1:0] state_address,
    input  logic [CODE_K-1:0]  input_address,
    input  logic [STATE_W-1:0] next_state_data,
    input  logic [CODE_N-1:0]  output_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_K-1:0]  data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_N-1:0]  encoded,
    output logic               out_last,
    output logic               done,
    output logic               term_ok
);

    enc_fsm_e           state_q, state_d;
    logic [STATE_W-1:0] enc_state_q, enc_state_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0]   sym_cnt_inc;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [CODE_N-1:0]  encoded_q, encoded_d;
    logic               can_gen;
    logic               gen;
    logic [CODE_K-1:0]  u;
    logic [STATE_W-1:0] tbl_next;
    logic [CODE_N-1:0]  tbl_out;

    trellis_table u_table (
        .clk      (clk),
        .reset    (reset),
        .we       (load),
        .wr_state (state_address),
        .wr_input (input_address),
        .wr_next  (next_state_data),
        .wr_out   (output_data),
        .rd_state (enc_state_q),
        .rd_input (u),
        .rd_next  (tbl_next),
        .rd_out   (tbl_out)
    );

    // A new symbol may enter the output register only if it is empty or draining now.
    assign can_gen     = !load && (!out_valid_q || out_ready);
    assign in_ready    = !reset && (state_q == RUN) && can_gen;
    assign u           = (state_q == RUN) ? data_in : '0;
    assign sym_cnt_inc = sym_cnt_q + 1'b1;

    always_comb begin
        gen = 1'b0;
        case (state_q)
            RUN:     gen = in_valid && in_ready;
            TAIL:    gen = can_gen;
            default: gen = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        enc_state_d = enc_state_q;
        sym_cnt_d   = sym_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        encoded_d   = encoded_q;
        if (restart) begin
            state_d     = RUN;
            enc_state_d = '0;
            sym_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (gen) begin
                encoded_d   = tbl_out;
                enc_state_d = tbl_next;
                out_valid_d = 1'b1;
                sym_cnt_d   = sym_cnt_inc;
                out_last_d  = (sym_cnt_q == CNT_W'(FRAME_L - 1));
                if (state_q == RUN && sym_cnt_inc == CNT_W'(DATA_SYMS))
                    state_d = TAIL;
                if (state_q == TAIL && sym_cnt_inc == CNT_W'(FRAME_L))
                    state_d = DONE;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            enc_state_q <= '0;
            sym_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            encoded_q   <= '0;
        end else begin
            state_q     <= state_d;
            enc_state_q <= enc_state_d;
            sym_cnt_q   <= sym_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            encoded_q   <= encoded_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign encoded   = encoded_q;
    assign done      = (state_q == DONE);
    assign term_ok   = (state_q == DONE) && (enc_state_q == '0);

endmodule

// File: tb/tb_conv_encoder_table.sv
// Bench for conv_encoder_table: frame vectors checked against constants and a
// generator-polynomial reference model, plus restart/reset/load/DONE sequences.
module tb_conv_encoder_table;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       load = 1'b0;
    logic [2:0] state_address = '0;
    logic [0:0] input_address = '0;
    logic [2:0] next_state_data = '0;
    logic [1:0] output_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [0:0] data_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] encoded;
    logic       out_last;
    logic       done;
    logic       term_ok;

    int n_pass = 0;
    int n_total = 0;

    conv_encoder_table dut (
        .clk(clk), .reset(reset), .restart(restart), .load(load),
        .state_address(state_address), .input_address(input_address),
        .next_state_data(next_state_data), .output_data(output_data),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .encoded(encoded),
        .out_last(out_last), .done(done), .term_ok(term_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: code generators g0=1111, g1=1011 over (u, s0, s1, s2).
    task automatic ref_frame(input logic [3:0] data, output logic [13:0] stream,
                             output logic [2:0] final_state);
        logic [2:0] sr;
        logic [3:0] win;
        logic       uu;
        sr = 3'b000;
        stream = '0;
        for (int i = 0; i < 7; i++) begin
            uu = (i < 4) ? data[3-i] : 1'b0;
            win = {uu, sr};
            stream = {stream[11:0], ^(win & 4'b1111), ^(win & 4'b1011)};
            sr = win[3:1];
        end
        final_state = sr;
    endtask

    task automatic load_table();
        logic s0, s1, s2;
        logic uu;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                @(negedge clk);
                s0 = s[2]; s1 = s[1]; s2 = s[0]; uu = u[0];
                load = 1'b1;
                state_address = s[2:0];
                input_address = uu;
                next_state_data = {uu, s0, s1};
                output_data = {uu ^ s0 ^ s1 ^ s2, uu ^ s1 ^ s2};
            end
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1; in_valid = 1'b0; load = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        restart = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready toggles, 2 random ready/valid, 3 load burst mid-frame
    task automatic do_frame(input string name, input logic [3:0] data, input int mode,
                            input logic [13:0] exp_stream, input logic exp_term);
        logic [13:0] got;
        int nsym, di, cyc, last_cnt, last_pos;
        bit hold_v, hold_l;
        logic [1:0] hold_e;
        got = '0; nsym = 0; di = 0; cyc = 0; last_cnt = 0; last_pos = 0;
        hold_v = 0; hold_l = 0; hold_e = '0;
        do_restart();
        while (!(nsym == 7 && done) && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            if (hold_v) begin
                chk({name, "_hold_enc"}, {30'd0, encoded}, {30'd0, hold_e});
                chk({name, "_hold_last"}, {31'd0, out_last}, {31'd0, hold_l});
            end
            in_valid = (di < 4) && (mode != 2 || $urandom_range(3) != 0);
            data_in = (di < 4) ? data[3-di] : 1'b0;
            case (mode)
                1: out_ready = (cyc % 2 == 0);
                2: out_ready = $urandom_range(1);
                default: out_ready = 1'b1;
            endcase
            load = (mode == 3) && cyc >= 2 && cyc <= 4;
            state_address = '0; input_address = '0; next_state_data = '0; output_data = '0;
            #1;
            if (load) chk({name, "_load_in_ready"}, {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready && nsym < 7) begin
                got = {got[11:0], encoded};
                nsym++;
                if (out_last) begin last_cnt++; last_pos = nsym; end
            end
            hold_v = out_valid && !out_ready;
            hold_e = encoded; hold_l = out_last;
            if (in_valid && in_ready) di++;
            cyc++;
        end
        if (cyc >= 200) chk({name, "_timeout"}, 32'd1, 32'd0);
        chk({name, "_stream"}, {18'd0, got}, {18'd0, exp_stream});
        chk({name, "_last_pos"}, last_pos, 7);
        chk({name, "_last_cnt"}, last_cnt, 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; load = 1'b0;
        #1;
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_term_ok"}, {31'd0, term_ok}, {31'd0, exp_term});
        chk({name, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  data;
        int          mode;
        logic [13:0] exp_stream;
        logic        exp_term;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [13:0] st;
        logic [2:0]  fs;

        vecs[0] = '{"t1_1011",     4'b1011, 0, 14'b11_10_00_10_01_00_11, 1'b1};
        vecs[1] = '{"t2_toggle",   4'b1011, 1, 14'b11_10_00_10_01_00_11, 1'b1};
        vecs[2] = '{"zeros",       4'b0000, 0, 14'b00_00_00_00_00_00_00, 1'b1};
        vecs[3] = '{"impulse",     4'b1000, 2, 14'b11_10_11_11_00_00_00, 1'b1};
        vecs[4] = '{"t3_loadhold", 4'b1011, 3, 14'b11_10_00_10_01_00_11, 1'b1};
        for (int i = 5; i < 8; i++) begin
            vecs[i].name = $sformatf("rand%0d", i);
            vecs[i].data = 4'($urandom_range(15));
            vecs[i].mode = 2;
            ref_frame(vecs[i].data, st, fs);
            vecs[i].exp_stream = st;
            vecs[i].exp_term = (fs == 3'b000);
        end

        #2;
        chk("rst_outputs", {26'd0, in_ready, out_valid, encoded, out_last, done, term_ok}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        load_table();

        for (int i = 0; i < 8; i++)
            do_frame(vecs[i].name, vecs[i].data, vecs[i].mode, vecs[i].exp_stream, vecs[i].exp_term);

        // t6: DONE ignores input until restart
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; data_in = 1'b1; out_ready = 1'b1;
            #1;
            chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
            chk("t6_done", {31'd0, done}, 32'd1);
        end
        do_restart();
        #1;
        chk("t6_done_cleared", {31'd0, done}, 32'd0);

        // t4: restart with a pending symbol drops it
        @(negedge clk); in_valid = 1'b1; data_in = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; data_in = 1'b0; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t4_pending", {30'd0, out_valid, 1'b0}, {30'd0, 2'b10});
        chk("t4_pending_enc", {30'd0, encoded}, 32'h2);
        do_restart();
        #1;
        chk("t4_dropped", {30'd0, out_valid, done}, 32'd0);
        do_frame("t4_after_restart", 4'b1011, 0, 14'b11_10_00_10_01_00_11, 1'b1);

        // t5: reset mid-TAIL, then the cleared table encodes all zeros
        do_restart();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; data_in = (i != 1); out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk("t5_tail_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_tail_out_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_outputs", {26'd0, in_ready, out_valid, encoded, out_last, done, term_ok}, 32'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        do_frame("t5_unloaded", 4'b1011, 0, 14'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
